// File: rtl/omem_write_buffer_if.sv
// Handshake bundle between the IO station OMEM write port, the write buffer
// and the downstream OMEM arbiter bus.
interface omem_write_buffer_if #(
  parameter int ADDR_WIDTH = 96,
  parameter int DATA_WIDTH = 96,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  iOMEMWriteEnable;
  logic [ADDR_WIDTH-1:0] iOMEMWriteAddress;
  logic [DATA_WIDTH-1:0] iOMEMWriteData;
  logic                  oBusValid;
  logic [ADDR_WIDTH-1:0] oBusAddress;
  logic [DATA_WIDTH-1:0] oBusData;
  logic                  iBusAccept;
  logic                  oFull;
  logic                  oEmpty;
  logic [CW-1:0]         oCount;
  logic                  oOverflow;
  logic                  iClearOverflow;

  modport slave (
    input  iOMEMWriteEnable, iOMEMWriteAddress, iOMEMWriteData,
    input  iBusAccept, iClearOverflow,
    output oBusValid, oBusAddress, oBusData, oFull, oEmpty, oCount, oOverflow
  );

  modport master (
    output iOMEMWriteEnable, iOMEMWriteAddress, iOMEMWriteData,
    output iBusAccept, iClearOverflow,
    input  oBusValid, oBusAddress, oBusData, oFull, oEmpty, oCount, oOverflow
  );
endinterface

// File: rtl/omem_write_buffer.sv
// Elastic FIFO between the no-back-pressure OMEM write strobe and the
// valid/accept output bus; writes arriving while full are dropped and flagged.
module omem_write_buffer #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 96,
  parameter int DEPTH      = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  omem_write_buffer_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push_s, pop_s, drop_s;

  // Push/pop decode and next-state for pointers, occupancy and sticky overflow
  always_comb begin
    pop_s      = (count_q != {CW{1'b0}}) & bus.iBusAccept;
    push_s     = bus.iOMEMWriteEnable & ((count_q < CW'(DEPTH)) | pop_s);
    drop_s     = bus.iOMEMWriteEnable & ~push_s;
    rd_ptr_d   = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d   = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear request keeps the flag set
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (bus.iClearOverflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; cleared on reset so the bus reads zero afterwards
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= {bus.iOMEMWriteAddress, bus.iOMEMWriteData};
    end
  end

  assign bus.oBusAddress = mem_q[rd_ptr_q][EW-1:DATA_WIDTH];
  assign bus.oBusData    = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign bus.oBusValid   = (count_q != {CW{1'b0}});
  assign bus.oEmpty      = (count_q == {CW{1'b0}});
  assign bus.oFull       = (count_q == CW'(DEPTH));
  assign bus.oCount      = count_q;
  assign bus.oOverflow   = overflow_q;
endmodule

// File: tb/tb_omem_write_buffer.sv
// Self-checking bench for omem_write_buffer: directed scenarios plus a random
// back-pressure run scored against a queue-based reference model.
module tb_omem_write_buffer;
  localparam int AW    = 96;
  localparam int DW    = 96;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [AW+DW-1:0] mq[$];
  bit               movf;

  omem_write_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  omem_write_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    d = {$urandom, $urandom, $urandom};
    return d;
  endfunction

  task automatic drive(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic acc, input logic clr);
    bus.iOMEMWriteEnable  = en;
    bus.iOMEMWriteAddress = a;
    bus.iOMEMWriteData    = d;
    bus.iBusAccept        = acc;
    bus.iClearOverflow    = clr;
  endtask

  // Reference behaviour of one clock edge, applied to a plain queue
  task automatic model_edge();
    bit pop, push;
    pop  = (mq.size() != 0) && bus.iBusAccept;
    push = bus.iOMEMWriteEnable && ((mq.size() < DEPTH) || pop);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({bus.iOMEMWriteAddress, bus.iOMEMWriteData});
    if (bus.iOMEMWriteEnable && !push) movf = 1'b1;
    else if (bus.iClearOverflow) movf = 1'b0;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    Reset = 1'b1;
    #12;
    total++; if (bus.oBusValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.oBusValid); end
    total++; if (bus.oEmpty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", bus.oEmpty); end
    total++; if (bus.oFull !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", bus.oFull); end
    total++; if (bus.oCount !== CW'(0)) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.oCount); end
    total++; if (bus.oOverflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", bus.oOverflow); end
    total++; if (bus.oBusAddress !== AW'(0) || bus.oBusData !== DW'(0)) begin
      bad++; $display("FAIL reset_bus got=%0h/%0h exp=0/0", bus.oBusAddress, bus.oBusData);
    end
    Reset = 1'b0;
    mq.delete();
    movf = 1'b0;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_single_write();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'(32'h10);
    d = DW'(16'hA5A5);
    drive(1'b1, a, d, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.oBusValid !== 1'b1 || bus.oBusAddress !== a || bus.oBusData !== d || bus.oCount !== CW'(1)) begin
        bad++; $display("FAIL single_hold cyc=%0d got v=%0b a=%0h d=%0h c=%0d exp v=1 a=%0h d=%0h c=1",
                        i, bus.oBusValid, bus.oBusAddress, bus.oBusData, bus.oCount, a, d);
      end
      cycle();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    total++; if (bus.oBusValid !== 1'b0 || bus.oEmpty !== 1'b1) begin
      bad++; $display("FAIL single_drain got v=%0b e=%0b exp v=0 e=1", bus.oBusValid, bus.oEmpty);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, AW'(i), rnd_data(), 1'b0, 1'b0);
      cycle();
      if (i == 6) begin
        total++; if (bus.oFull !== 1'b0) begin bad++; $display("FAIL fill_early_full got=%0b exp=0", bus.oFull); end
      end
      if (i == 7) begin
        total++; if (bus.oFull !== 1'b1 || bus.oOverflow !== 1'b0) begin
          bad++; $display("FAIL fill_full got f=%0b o=%0b exp f=1 o=0", bus.oFull, bus.oOverflow);
        end
      end
    end
    total++; if (bus.oOverflow !== 1'b1 || bus.oCount !== CW'(DEPTH)) begin
      bad++; $display("FAIL fill_drop got o=%0b c=%0d exp o=1 c=%0d", bus.oOverflow, bus.oCount, DEPTH);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int j = 0; j < DEPTH; j++) begin
      total++; if (bus.oBusValid !== 1'b1 || bus.oBusAddress !== AW'(j) || bus.oBusData !== mq[0][DW-1:0]) begin
        bad++; $display("FAIL fill_order idx=%0d got v=%0b a=%0h d=%0h exp a=%0h d=%0h",
                        j, bus.oBusValid, bus.oBusAddress, bus.oBusData, j, mq[0][DW-1:0]);
      end
      cycle();
    end
    total++; if (bus.oEmpty !== 1'b1 || bus.oOverflow !== 1'b1) begin
      bad++; $display("FAIL fill_drained got e=%0b o=%0b exp e=1 o=1", bus.oEmpty, bus.oOverflow);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    total++; if (bus.oOverflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b exp=0", bus.oOverflow); end
  endtask

  task automatic test_full_push_pop();
    logic [AW-1:0] last;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, AW'(32'h20 + i), rnd_data(), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, AW'(32'h99), rnd_data(), 1'b1, 1'b0);
    cycle();
    total++; if (bus.oOverflow !== 1'b0 || bus.oCount !== CW'(DEPTH) || bus.oFull !== 1'b1) begin
      bad++; $display("FAIL fullpp got o=%0b c=%0d f=%0b exp o=0 c=%0d f=1", bus.oOverflow, bus.oCount, bus.oFull, DEPTH);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    last = '0;
    for (int j = 0; j < DEPTH; j++) begin
      total++; if (bus.oBusAddress !== mq[0][AW+DW-1:DW] || bus.oBusData !== mq[0][DW-1:0]) begin
        bad++; $display("FAIL fullpp_order idx=%0d got a=%0h exp a=%0h", j, bus.oBusAddress, mq[0][AW+DW-1:DW]);
      end
      last = bus.oBusAddress;
      cycle();
    end
    total++; if (last !== AW'(32'h99) || bus.oEmpty !== 1'b1) begin
      bad++; $display("FAIL fullpp_last got a=%0h e=%0b exp a=99 e=1", last, bus.oEmpty);
    end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] d;
    for (int i = 0; i < 20; i++) begin
      d = rnd_data();
      drive(1'b1, AW'(32'h100 + i), d, 1'b1, 1'b0);
      cycle();
      total++; if (bus.oBusValid !== 1'b1 || bus.oBusAddress !== AW'(32'h100 + i) || bus.oBusData !== d || bus.oCount !== CW'(1)) begin
        bad++; $display("FAIL stream idx=%0d got v=%0b a=%0h c=%0d exp v=1 a=%0h c=1",
                        i, bus.oBusValid, bus.oBusAddress, bus.oCount, 32'h100 + i);
      end
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cycle();
    total++; if (bus.oEmpty !== 1'b1) begin bad++; $display("FAIL stream_end got e=%0b exp=1", bus.oEmpty); end
  endtask

  task automatic test_random();
    int strobes;
    int cyc;
    logic en;
    strobes = 0;
    cyc = 0;
    while (strobes < 200 && cyc < 2000) begin
      en = ($urandom_range(0, 9) < 6);
      if (en) strobes++;
      drive(en, {$urandom, $urandom, $urandom}, rnd_data(), logic'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0));
      cycle();
      cyc++;
      total++; if (bus.oCount !== CW'(mq.size()) || bus.oBusValid !== (mq.size() != 0) ||
                   bus.oFull !== (mq.size() == DEPTH) || bus.oEmpty !== (mq.size() == 0)) begin
        bad++; $display("FAIL rnd_state cyc=%0d got c=%0d v=%0b f=%0b e=%0b exp c=%0d",
                        cyc, bus.oCount, bus.oBusValid, bus.oFull, bus.oEmpty, mq.size());
      end
      total++; if (bus.oOverflow !== movf) begin
        bad++; $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", cyc, bus.oOverflow, movf);
      end
      if (mq.size() != 0) begin
        total++; if (bus.oBusAddress !== mq[0][AW+DW-1:DW] || bus.oBusData !== mq[0][DW-1:0]) begin
          bad++; $display("FAIL rnd_head cyc=%0d got a=%0h d=%0h exp a=%0h d=%0h",
                          cyc, bus.oBusAddress, bus.oBusData, mq[0][AW+DW-1:DW], mq[0][DW-1:0]);
        end
      end
    end
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    total++; if (bus.oEmpty !== 1'b1 || bus.oOverflow !== 1'b0) begin
      bad++; $display("FAIL rnd_drain got e=%0b o=%0b exp e=1 o=0", bus.oEmpty, bus.oOverflow);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1'b1, AW'(32'h40 + i), rnd_data(), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    total++; if (bus.oCount !== CW'(5) || bus.oOverflow !== 1'b1) begin
      bad++; $display("FAIL midrst_pre got c=%0d o=%0b exp c=5 o=1", bus.oCount, bus.oOverflow);
    end
    #2 Reset = 1'b1;
    #1;
    total++; if (bus.oCount !== CW'(0) || bus.oOverflow !== 1'b0 || bus.oBusValid !== 1'b0 ||
                 bus.oEmpty !== 1'b1 || bus.oFull !== 1'b0 || bus.oBusAddress !== AW'(0) || bus.oBusData !== DW'(0)) begin
      bad++; $display("FAIL midrst got c=%0d o=%0b v=%0b e=%0b f=%0b a=%0h exp all reset",
                      bus.oCount, bus.oOverflow, bus.oBusValid, bus.oEmpty, bus.oFull, bus.oBusAddress);
    end
    #1 Reset = 1'b0;
    mq.delete();
    movf = 1'b0;
    @(posedge Clock);
    #1;
    test_single_write();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_overflow();
    test_full_push_pop();
    test_streaming();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/omem_write_buffer.md
# omem_write_buffer

Elastic write buffer between the execution unit's IO station OMEM write port and the external output-memory bus. The execution unit issues OMEM writes as single-cycle strobes with no back-pressure. This block captures each strobe (address plus data row) into a FIFO and drains it over a valid/accept handshake toward the OMEM arbiter. Writes that arrive while the FIFO is full are dropped and flagged with a sticky overflow bit for software and debug visibility.

## Interface
- DATA_WIDTH, default 96: OMEM data row width (`DATA_ROW_WIDTH`).
- ADDR_WIDTH, default 96: OMEM address width, equal to the IO station's address output width.
- DEPTH, default 8: number of FIFO entries. Must be a power of two and at least 2.
- Clock  in  1  single clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- iOMEMWriteEnable  in  1  one-cycle write strobe from the IO station.
- iOMEMWriteAddress  in  ADDR_WIDTH  write address; sampled when the strobe is high.
- iOMEMWriteData  in  DATA_WIDTH  write data; sampled when the strobe is high.
- oBusValid  out  1  head entry is present on the bus outputs.
- oBusAddress  out  ADDR_WIDTH  address of the head entry.
- oBusData  out  DATA_WIDTH  data of the head entry.
- iBusAccept  in  1  downstream consumes the head entry on this edge.
- oFull  out  1  count equals DEPTH.
- oEmpty  out  1  count equals 0.
- oCount  out  log2(DEPTH)+1  current occupancy.
- oOverflow  out  1  sticky flag: at least one write was dropped.
- iClearOverflow  in  1  synchronous clear of oOverflow.

## Operation
- Storage:
  - DEPTH entries, each holding {address, data}.
  - Read pointer and write pointer are log2(DEPTH) bits each and wrap modulo DEPTH.
  - A separate count register runs from 0 to DEPTH.
- Push is the condition iOMEMWriteEnable & (count < DEPTH | pop).
- Pop is the condition oBusValid & iBusAccept.
- On push: the entry is written at the write pointer, and the write pointer increments.
- On pop: the read pointer increments.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- When full, a write is accepted only if a pop happens in the same cycle.
- Drop: iOMEMWriteEnable & ~push.
  - Storage, pointers and count are unchanged.
  - oOverflow is set on the next edge.
- oOverflow priority: set wins over iClearOverflow when both occur in the same cycle. Otherwise iClearOverflow clears it.
- oBusAddress and oBusData always show the entry at the read pointer, read combinationally from registered storage.
  - Their contents are meaningful only while oBusValid is 1.
  - They must stay stable while oBusValid=1 and iBusAccept=0.
- oBusValid = (count != 0); oEmpty = (count == 0); oFull = (count == DEPTH). All three are decoded from registers, with no combinational path from iBusAccept or iOMEMWriteEnable.
- iBusAccept while oBusValid=0 is ignored.
- Entries drain in strict FIFO order. Addresses are not merged or coalesced.

## Timing
- Reset (asynchronous, at any time, including mid-drain):
  - pointers and count go to 0 and all storage is cleared.
  - oOverflow=0, oBusValid=0, oEmpty=1, oFull=0, oCount=0.
  - oBusAddress and oBusData read 0.
  - In-flight entries are discarded.
- Write-to-valid latency is 1 cycle. A strobe in cycle N into an empty FIFO gives oBusValid=1 in cycle N+1, carrying that address and data.
- Throughput is one push and one pop per cycle, sustained.
- At steady state with iBusAccept held at 1, every strobe appears on the bus for exactly one cycle, one cycle after its arrival.
- Pop in cycle N means the next entry, if any, is presented in cycle N+1.
- oFull asserts in the cycle after the push that makes count equal DEPTH. oEmpty reasserts in the cycle after the final pop.
- oOverflow asserts the cycle after the dropped strobe and holds until cleared.
- Pointer wrap: after DEPTH pushes the write pointer returns to 0 with no gap or bubble.

## Test plan
- Reset then single write:
  - Stimulus: strobe with addr=0x10, data=0xA5A5, iBusAccept=0.
  - Response: next cycle oBusValid=1, oBusAddress=0x10, oBusData=0xA5A5, oCount=1. Outputs hold while accept stays 0.
  - Then accept for one cycle: oBusValid=0, oEmpty=1.
- Fill and overflow:
  - Stimulus: 9 consecutive strobes, addr 0..8, accept=0.
  - Response: oFull=1 after the 8th; the 9th is dropped and oOverflow=1.
  - Then accept continuously: addresses 0..7 drain in order, with no address 8.
  - iClearOverflow then clears the flag.
- Full plus simultaneous push/pop:
  - Stimulus: with the FIFO full, strobe addr=0x99 while accept=1.
  - Response: no overflow, oCount stays 8, and 0x99 drains last.
- Streaming wrap:
  - Stimulus: 20 back-to-back strobes with accept=1 throughout.
  - Response: each address appears exactly one cycle after its strobe. oCount never exceeds 1. Pointers wrap twice.
- Random back-pressure:
  - Stimulus: 200 random strobes against random accept (50% duty).
  - Response: the scoreboard sees an in-order, lossless sequence whenever oOverflow stays 0. oCount always equals accepted pushes minus pops.
- Mid-operation reset:
  - Stimulus: with 5 entries held and oOverflow=1, pulse Reset asynchronously between clock edges.
  - Response: all outputs take their reset values immediately. A subsequent write behaves as in the first scenario.
